// File: rtl/meeting_megaphone_animator.sv
// rtl/meeting_megaphone_animator.sv - megaphone sprite slide-in/hold/slide-out animator with ROM addressing
// Optional build macro MEGAPHONE_BLINK_EN: blink the sprite every 8 frames while held.
module meeting_megaphone_animator #(
    parameter int SPR_W       = 64,
    parameter int SPR_H       = 64,
    parameter int SCREEN_W    = 640,
    parameter int Y_POS       = 208,
    parameter int X_HOLD      = 288,
    parameter int SLIDE_STEP  = 8,
    parameter int HOLD_FRAMES = 120
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_start,
    input  logic        meeting_trig,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [2:0]  megaphone_out,
    output logic [18:0] read_address,
    output logic [2:0]  pix_color,
    output logic        pix_valid,
    output logic        busy,
    output logic        done
);

    localparam int CW     = $clog2(SPR_W);
    localparam int RW     = $clog2(SPR_H);
    localparam int HCW_MIN = $clog2(HOLD_FRAMES);
    // At least 4 bits so the blink phase bit always exists.
    localparam int HCW    = (HCW_MIN > 4) ? HCW_MIN : 4;

    localparam logic signed [10:0] X_START  = 11'(-SPR_W);
    localparam logic signed [10:0] X_HOLD_S = 11'(X_HOLD);
    localparam logic signed [10:0] X_END_S  = 11'(SCREEN_W);
    localparam logic signed [10:0] STEP_S   = 11'(SLIDE_STEP);
    localparam logic signed [10:0] SPR_W_S  = 11'(SPR_W);
    localparam logic signed [10:0] SPR_H_S  = 11'(SPR_H);
    localparam logic signed [10:0] Y_POS_S  = 11'(Y_POS);
    localparam logic [HCW-1:0]     HOLD_LAST = HCW'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SLIDE_IN  = 2'd1,
        HOLD      = 2'd2,
        SLIDE_OUT = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic signed [10:0]      spr_x_q, spr_x_d;
    logic signed [10:0]      spr_x_step;
    logic [HCW-1:0]          hold_cnt_q, hold_cnt_d;
    logic                    done_q, done_d;
    logic [2:0]              pix_color_q, pix_color_d;
    logic                    pix_valid_q, pix_valid_d;

    logic signed [10:0]      col;
    logic signed [10:0]      row;
    logic                    in_box;
    logic                    vis;
    logic                    show;
    logic [RW+CW-1:0]        addr_raw;

    assign spr_x_step = spr_x_q + STEP_S;

    // Position only moves on frame_start so a frame is never drawn with two positions.
    always_comb begin
        state_d    = state_q;
        spr_x_d    = spr_x_q;
        hold_cnt_d = hold_cnt_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (meeting_trig) begin
                    state_d = SLIDE_IN;
                    spr_x_d = X_START;
                end
            end
            SLIDE_IN: begin
                if (frame_start) begin
                    if (spr_x_step >= X_HOLD_S) begin
                        spr_x_d    = X_HOLD_S;
                        hold_cnt_d = '0;
                        state_d    = HOLD;
                    end else begin
                        spr_x_d = spr_x_step;
                    end
                end
            end
            HOLD: begin
                if (meeting_trig) begin
                    hold_cnt_d = '0;
                end else if (frame_start) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = SLIDE_OUT;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HCW'(1);
                    end
                end
            end
            SLIDE_OUT: begin
                if (frame_start) begin
                    if (spr_x_step >= X_END_S) begin
                        spr_x_d = X_START;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        spr_x_d = spr_x_step;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                spr_x_d = X_START;
            end
        endcase
    end

    assign col      = $signed({1'b0, DrawX}) - spr_x_q;
    assign row      = $signed({1'b0, DrawY}) - Y_POS_S;
    assign in_box   = !col[10] && (col < SPR_W_S) && !row[10] && (row < SPR_H_S);
    assign addr_raw = {row[RW-1:0], col[CW-1:0]};
    assign read_address = in_box ? 19'(addr_raw) : 19'd0;

`ifdef MEGAPHONE_BLINK_EN
    assign vis = (state_q == HOLD) ? ~hold_cnt_q[3] : 1'b1;
`else
    assign vis = 1'b1;
`endif

    assign show        = in_box && (state_q != IDLE) && vis;
    assign pix_color_d = show ? megaphone_out : 3'd0;
    assign pix_valid_d = show && (megaphone_out != 3'd0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            spr_x_q     <= X_START;
            hold_cnt_q  <= '0;
            done_q      <= 1'b0;
            pix_color_q <= 3'd0;
            pix_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            spr_x_q     <= spr_x_d;
            hold_cnt_q  <= hold_cnt_d;
            done_q      <= done_d;
            pix_color_q <= pix_color_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    assign pix_color = pix_color_q;
    assign pix_valid = pix_valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_meeting_megaphone_animator.sv
// tb/tb_meeting_megaphone_animator.sv - self-checking bench for meeting_megaphone_animator
module tb_meeting_megaphone_animator;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        frame_start = 1'b0;
    logic        meeting_trig = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic [2:0]  megaphone_out;
    logic [18:0] read_address;
    logic [2:0]  pix_color;
    logic        pix_valid;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    // Phase 0 idle, 1 sliding in, 2 held, 3 sliding out; m_n counts frames within the phase.
    int m_phase = 0;
    int m_n = 0;
    bit m_done = 0;

    always #5 Clk = ~Clk;

    function automatic logic [2:0] rom(input logic [18:0] a);
        logic [18:0] t;
        t = (a ^ (a >> 4)) * 19'd5;
        return t[2:0];
    endfunction

    assign megaphone_out = rom(read_address);

    meeting_megaphone_animator dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_start  (frame_start),
        .meeting_trig (meeting_trig),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .megaphone_out(megaphone_out),
        .read_address (read_address),
        .pix_color    (pix_color),
        .pix_valid    (pix_valid),
        .busy         (busy),
        .done         (done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic int model_x();
        case (m_phase)
            1:       return -64 + 8 * m_n;
            2:       return 288;
            3:       return 288 + 8 * m_n;
            default: return -64;
        endcase
    endfunction

    function automatic bit model_vis();
`ifdef MEGAPHONE_BLINK_EN
        return !(m_phase == 2 && ((m_n / 8) % 2 == 1));
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_step(input bit fs, input bit tr);
        m_done = 0;
        case (m_phase)
            0: if (tr) begin m_phase = 1; m_n = 0; end
            1: if (fs) begin
                m_n++;
                if (-64 + 8 * m_n >= 288) begin m_phase = 2; m_n = 0; end
            end
            2: if (tr) m_n = 0;
               else if (fs) begin
                m_n++;
                if (m_n == 120) begin m_phase = 3; m_n = 0; end
            end
            3: if (fs) begin
                m_n++;
                if (288 + 8 * m_n >= 640) begin m_phase = 0; m_n = 0; m_done = 1; end
            end
            default: m_phase = 0;
        endcase
    endtask

    // Called at posedge+1 with inputs already set; checks the address now and the registered outputs after the edge.
    task automatic tick();
        int col, row, ea;
        bit ib;
        logic [2:0] ec;
        col = int'(DrawX) - model_x();
        row = int'(DrawY) - 208;
        ib  = (col >= 0) && (col < 64) && (row >= 0) && (row < 64);
        ea  = ib ? row * 64 + col : 0;
        #1;
        chk("read_address", read_address, ea);
        ec = (ib && m_phase != 0 && model_vis()) ? rom(19'(ea)) : 3'd0;
        @(posedge Clk);
        #1;
        model_step(frame_start, meeting_trig);
        frame_start  = 1'b0;
        meeting_trig = 1'b0;
        chk("pix_color", pix_color, ec);
        chk("pix_valid", pix_valid, ec != 3'd0);
        chk("busy", busy, m_phase != 0);
        chk("done", done, m_done);
    endtask

    task automatic frames(input int k);
        for (int i = 0; i < k; i++) begin
            frame_start = 1'b1;
            tick();
        end
    endtask

    typedef struct {
        int dx;
        int dy;
        int addr;
        bit shown;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int xr;
        tbl[0] = '{290, 210, 130, 1'b1};
        tbl[1] = '{288, 208, 0, 1'b1};
        tbl[2] = '{351, 271, 4095, 1'b1};
        tbl[3] = '{352, 210, 0, 1'b0};
        tbl[4] = '{287, 210, 0, 1'b0};
        tbl[5] = '{300, 272, 0, 1'b0};
        tbl[6] = '{289, 271, 4033, 1'b1};
        tbl[7] = '{300, 207, 0, 1'b0};

        #2 Reset_n = 1'b0;
        #1;
        chk("rst_addr", read_address, 0);
        chk("rst_pix_color", pix_color, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge Clk); @(posedge Clk); #1;
        Reset_n = 1'b1;

        // Trigger and frame_start together: the frame is ignored, sprite stays at -64.
        DrawX = 10'd0; DrawY = 10'd210;
        meeting_trig = 1'b1; frame_start = 1'b1;
        tick();
        chk("trig_fs_same_addr", read_address, 0);
        chk("trig_busy", busy, 1);
        frames(1);
        chk("left_clip_addr", read_address, 184);
        tick();
        chk("left_clip_pix", pix_color, rom(19'd184));
        chk("left_clip_valid", pix_valid, rom(19'd184) != 3'd0);

        frames(43);
        DrawX = 10'd290; DrawY = 10'd210;
        #1;
        chk("hold_addr_130", read_address, 130);
        tick();
        chk("hold_pix_130", pix_color, rom(19'd130));
        chk("hold_valid_130", pix_valid, rom(19'd130) != 3'd0);

        for (int i = 0; i < 8; i++) begin
            DrawX = 10'(tbl[i].dx); DrawY = 10'(tbl[i].dy);
            #1;
            chk("tbl_addr", read_address, tbl[i].addr);
            tick();
            chk("tbl_pix", pix_color, tbl[i].shown ? rom(19'(tbl[i].addr)) : 3'd0);
        end

        // Retrigger at hold frame 50 restarts the 120-frame hold.
        DrawX = 10'd290; DrawY = 10'd210;
        frames(50);
        meeting_trig = 1'b1;
        tick();
        frames(119);
        chk("hold_extended_addr", read_address, 130);
        chk("hold_extended_busy", busy, 1);
        frames(1);
        frames(1);
        chk("slide_out_moved", read_address, 0);
        frames(42);
        chk("before_done", done, 0);
        frames(1);
        chk("done_pulse", done, 1);
        chk("done_busy_low", busy, 0);
        tick();
        chk("done_one_cycle", done, 0);

        // Asynchronous reset mid-animation with the sprite under the beam.
        meeting_trig = 1'b1;
        tick();
        frames(44);
        DrawX = 10'd300; DrawY = 10'd230;
        tick();
        #2 Reset_n = 1'b0;
        #1;
        m_phase = 0; m_n = 0; m_done = 0;
        chk("midrst_busy", busy, 0);
        chk("midrst_pix_color", pix_color, 0);
        chk("midrst_pix_valid", pix_valid, 0);
        chk("midrst_addr", read_address, 0);
        chk("midrst_done", done, 0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        tick();

        for (int c = 0; c < 4000; c++) begin
            frame_start  = ($urandom_range(0, 2) == 0);
            meeting_trig = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 1) == 1) begin
                xr = model_x() + int'($urandom_range(0, 71)) - 4;
                if (xr < 0) xr = 0;
                if (xr > 1023) xr = 1023;
                DrawX = 10'(xr);
            end else begin
                DrawX = 10'($urandom_range(0, 1023));
            end
            DrawY = 10'($urandom_range(200, 280));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
